// File: rtl/glitch_clk_sched.sv
// Glitch clock-select scheduler: arm, wait for trigger edge, delay, then emit glitch pulse bursts on clk_sel_o.
// Optional ARMED wait timeout is compiled in with `define GLITCH_SCHED_TIMEOUT_EN.
module glitch_clk_sched #(
    parameter int unsigned DLY_W   = 16,
    parameter int unsigned WID_W   = 8,
    parameter int unsigned GAP_W   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [WID_W-1:0] cfg_width,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [3:0]       cfg_repeat,
    input  logic             trig_i,
    output logic             clk_sel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] glitch_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_GLITCH,
        S_GAP,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_trig_s1;
    logic               r_trig_s2;
    logic               r_trig_s3;
    logic               w_trig_edge;

    logic [DLY_W-1:0]   r_cfg_delay;
    logic [WID_W-1:0]   r_cfg_width;
    logic [GAP_W-1:0]   r_cfg_gap;
    logic [3:0]         r_remaining;

    logic [DLY_W-1:0]   r_cnt_dly;
    logic [WID_W-1:0]   r_cnt_wid;
    logic [GAP_W-1:0]   r_cnt_gap;
    logic [WID_W-1:0]   w_width_eff;
    logic [GAP_W-1:0]   w_gap_eff;

    logic               r_clk_sel;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_glitch_cnt;

    logic               w_arm_accept;
    logic               w_timeout_hit;

    // Trigger synchronizer plus one extra stage for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_s1 <= 1'b0;
            r_trig_s2 <= 1'b0;
            r_trig_s3 <= 1'b0;
        end else begin
            r_trig_s1 <= trig_i;
            r_trig_s2 <= r_trig_s1;
            r_trig_s3 <= r_trig_s2;
        end
    end

    assign w_trig_edge  = r_trig_s2 & ~r_trig_s3;
    assign w_arm_accept = (r_state == S_IDLE) && arm_i && !abort_i;
    assign w_width_eff  = (r_cfg_width == '0) ? WID_W'(1) : r_cfg_width;
    assign w_gap_eff    = (r_cfg_gap == '0) ? GAP_W'(1) : r_cfg_gap;

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        if (abort_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm_i) w_state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    if (w_trig_edge)
                        w_state_nxt = (r_cfg_delay == '0) ? S_GLITCH : S_DELAY;
                    else if (w_timeout_hit)
                        w_state_nxt = S_IDLE;
                end
                S_DELAY: begin
                    if (r_cnt_dly == DLY_W'(1)) w_state_nxt = S_GLITCH;
                end
                S_GLITCH: begin
                    if (r_cnt_wid == WID_W'(1))
                        w_state_nxt = (r_remaining == 4'd0) ? S_DONE : S_GAP;
                end
                S_GAP: begin
                    if (r_cnt_gap == GAP_W'(1)) w_state_nxt = S_GLITCH;
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, registered outputs and sequence counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_clk_sel    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_glitch_cnt <= '0;
            r_cfg_delay  <= '0;
            r_cfg_width  <= '0;
            r_cfg_gap    <= '0;
            r_remaining  <= 4'd0;
            r_cnt_dly    <= '0;
            r_cnt_wid    <= '0;
            r_cnt_gap    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_sel <= (w_state_nxt == S_GLITCH);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);

            if (w_arm_accept) begin
                r_cfg_delay <= cfg_delay;
                r_cfg_width <= cfg_width;
                r_cfg_gap   <= cfg_gap;
                r_remaining <= cfg_repeat;
            end

            if ((w_state_nxt == S_DELAY) && (r_state != S_DELAY))
                r_cnt_dly <= r_cfg_delay;
            else if (r_state == S_DELAY)
                r_cnt_dly <= r_cnt_dly - DLY_W'(1);

            if ((w_state_nxt == S_GLITCH) && (r_state != S_GLITCH)) begin
                r_cnt_wid <= w_width_eff;
                if (r_glitch_cnt != '1)
                    r_glitch_cnt <= r_glitch_cnt + CNT_W'(1);
            end else if (r_state == S_GLITCH) begin
                r_cnt_wid <= r_cnt_wid - WID_W'(1);
            end

            if ((w_state_nxt == S_GAP) && (r_state != S_GAP)) begin
                r_cnt_gap   <= w_gap_eff;
                r_remaining <= r_remaining - 4'd1;
            end else if (r_state == S_GAP) begin
                r_cnt_gap <= r_cnt_gap - GAP_W'(1);
            end
        end
    end

`ifdef GLITCH_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TO_W-1:0] r_wait;
    logic            r_timeout;
    logic            w_timeout_fire;

    assign w_timeout_hit  = (r_state == S_ARMED) && (r_wait == TO_W'(TIMEOUT - 1));
    assign w_timeout_fire = w_timeout_hit && !w_trig_edge && !abort_i;

    // ARMED wait counter; zero outside ARMED so each arm starts a fresh window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != S_ARMED)
                r_wait <= '0;
            else
                r_wait <= r_wait + TO_W'(1);

            if (w_arm_accept)
                r_timeout <= 1'b0;
            else if (w_timeout_fire)
                r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unused_timeout;

    assign w_timeout_hit    = 1'b0;
    assign timeout_o        = 1'b0;
    assign w_unused_timeout = (TIMEOUT == 0);
`endif

    assign clk_sel_o    = r_clk_sel;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign glitch_cnt_o = r_glitch_cnt;

endmodule

// File: tb/tb_glitch_clk_sched.sv
// Self-checking bench for glitch_clk_sched: directed and randomized sequences against a pulse-schedule model.
module tb_glitch_clk_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm_i;
    logic        abort_i;
    logic [15:0] cfg_delay;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_gap;
    logic [3:0]  cfg_repeat;
    logic        trig_i;
    logic        clk_sel_o;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [15:0] glitch_cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int gcnt_exp = 0;

    glitch_clk_sched #(
        .DLY_W(16), .WID_W(8), .GAP_W(8), .CNT_W(16), .TIMEOUT(100)
    ) dut (
        .clk(clk), .rst(rst), .arm_i(arm_i), .abort_i(abort_i),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
        .cfg_repeat(cfg_repeat), .trig_i(trig_i), .clk_sel_o(clk_sel_o),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .glitch_cnt_o(glitch_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sel"},  32'(clk_sel_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o),    32'd0);
        chk({tag, "_done"}, 32'(done_o),    32'd0);
    endtask

    task automatic randomize_cfg();
        cfg_delay  = 16'($urandom);
        cfg_width  = 8'($urandom);
        cfg_gap    = 8'($urandom);
        cfg_repeat = 4'($urandom);
    endtask

    // Arm with the given config; returns on the negedge after the arm edge
    task automatic do_arm(input int d, input int w, input int g, input int r);
        @(negedge clk);
        cfg_delay  = 16'(d);
        cfg_width  = 8'(w);
        cfg_gap    = 8'(g);
        cfg_repeat = 4'(r);
        arm_i      = 1'b1;
        @(negedge clk);
        arm_i = 1'b0;
        randomize_cfg();
    endtask

    // Full sequence; expected waveform is derived from pulse start/width/period arithmetic
    task automatic run_seq(input int d, input int w, input int g, input int r, input int pre);
        int k, we, ge, per, first, done_c, m, off;
        logic exp_sel;
        do_arm(d, w, g, r);
        chk("arm_busy", 32'(busy_o), 32'd1);
        repeat (pre) begin
            @(negedge clk);
            chk("armed_sel", 32'(clk_sel_o), 32'd0);
            chk("armed_busy", 32'(busy_o), 32'd1);
        end
        trig_i = 1'b1;
        k      = cyc + 1;
        we     = (w == 0) ? 1 : w;
        ge     = (g == 0) ? 1 : g;
        per    = we + ge;
        first  = k + 2 + d;
        done_c = first + r * per + we;
        forever begin
            @(negedge clk);
            m       = cyc;
            off     = m - first;
            exp_sel = (off >= 0) && (off < r * per + we) && ((off % per) < we);
            chk("seq_sel",  32'(clk_sel_o), 32'(exp_sel));
            chk("seq_done", 32'(done_o),    32'(m == done_c));
            chk("seq_busy", 32'(busy_o),    32'(m <= done_c));
            if (m > done_c) break;
            if (m < done_c) begin
                // Late trigger edges, arm pulses and cfg changes must all be ignored
                trig_i = (m - k < 2) ? 1'b1 : 1'($urandom);
                arm_i  = (($urandom % 8) == 0);
                randomize_cfg();
            end else begin
                trig_i = 1'b0;
                arm_i  = 1'b0;
            end
        end
        gcnt_exp = (gcnt_exp + r + 1 > 65535) ? 65535 : gcnt_exp + r + 1;
        chk("glitch_cnt", 32'(glitch_cnt_o), 32'(gcnt_exp));
        repeat (3) begin
            @(negedge clk);
            chk_idle("post");
        end
    endtask

    initial begin
        int k;
        rst = 1'b1; arm_i = 1'b0; abort_i = 1'b0; trig_i = 1'b0;
        cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_repeat = '0;
        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_cnt", 32'(glitch_cnt_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_seq(5, 3, 0, 0, 2);      // single pulse: high k+7..k+9, done k+10
        run_seq(0, 2, 4, 2, 0);      // burst: three 2-cycle pulses, 4-cycle gaps
        run_seq(3, 0, 0, 1, 1);      // zero width/gap treated as 1
        run_seq(1, 1, 1, 15, 1);     // maximum repeat count
        run_seq(300, 255, 0, 1, 0);  // all-ones width, long delay
        for (int s = 0; s < 16; s++)
            run_seq($urandom_range(0, 20), $urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(0, 3), $urandom_range(0, 4));

        // abort_i during GAP: IDLE next cycle, no done
        do_arm(0, 2, 4, 2);
        trig_i = 1'b1;
        k = cyc + 1;
        while (cyc < k + 5) @(negedge clk);
        chk("abort_pre_sel", 32'(clk_sel_o), 32'd0);
        chk("abort_pre_busy", 32'(busy_o), 32'd1);
        abort_i = 1'b1;
        trig_i  = 1'b0;
        @(negedge clk);
        abort_i = 1'b0;
        chk_idle("abort");
        gcnt_exp++;
        repeat (12) begin
            @(negedge clk);
            chk_idle("abort_after");
        end
        chk("abort_cnt", 32'(glitch_cnt_o), 32'(gcnt_exp));

        // abort and arm together in IDLE: stays IDLE
        @(negedge clk);
        arm_i = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        arm_i = 1'b0; abort_i = 1'b0;
        chk_idle("arm_abort");
        repeat (2) @(negedge clk);

        // Reset mid-GLITCH drops clk_sel_o without waiting for a clock edge
        do_arm(0, 50, 1, 0);
        trig_i = 1'b1;
        k = cyc + 1;
        while (cyc < k + 5) @(negedge clk);
        chk("pre_rst_sel", 32'(clk_sel_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk_idle("async_rst");
        chk("async_rst_cnt", 32'(glitch_cnt_o), 32'd0);
        chk("async_rst_to", 32'(timeout_o), 32'd0);
        gcnt_exp = 0;
        trig_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef GLITCH_SCHED_TIMEOUT_EN
        // ARMED with no trigger times out after exactly 100 cycles
        do_arm(4, 1, 1, 0);
        for (int i = 0; i < 99; i++) @(negedge clk);
        chk("to_busy_last", 32'(busy_o), 32'd1);
        chk("to_flag_early", 32'(timeout_o), 32'd0);
        @(negedge clk);
        chk_idle("to_expired");
        chk("to_flag", 32'(timeout_o), 32'd1);
        repeat (3) @(negedge clk);
        chk("to_sticky", 32'(timeout_o), 32'd1);
        do_arm(4, 1, 1, 0);
        chk("to_rearm_clr", 32'(timeout_o), 32'd0);
        chk("to_rearm_busy", 32'(busy_o), 32'd1);
`else
        // Without the timeout feature ARMED waits indefinitely
        do_arm(4, 1, 1, 0);
        repeat (150) @(negedge clk);
        chk("noto_busy", 32'(busy_o), 32'd1);
        chk("noto_flag", 32'(timeout_o), 32'd0);
`endif
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk_idle("final_abort");
        chk("final_cnt", 32'(glitch_cnt_o), 32'(gcnt_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
